hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Parametrised hazard scoreboard and forwarding mux for the in-order pipeline.
//  Tracks the destination register and remaining latency (t_new) of every
//  in-flight producer across STAGES post-decode stages. For NSRC decode-stage
//  source operands it generates the stall request and the forwarded value.
//  Sits beside the decode stage and replaces the per-stage ad-hoc stall/forward logic.
// PARAMETERS
//  STAGES  3   tracked stages after decode (entry 0 = EX ... STAGES-1 = writeback)
//  NSRC    2   number of source operands checked per decoded instruction
//  AW      5   register address width
//  DW      32  data width
//  TW      2   t_new / t_use width
//  CNT_W   32  width of the stall performance counter
// PORTS
//  clk          in   1          clock
//  reset        in   1          asynchronous reset, active-low
//  dec_valid    in   1          decode holds a real instruction
//  dec_a_new    in   AW         decode destination register (0 = none)
//  dec_t_new    in   TW         cycles from decode until the result exists
//  use_a        in   NSRC*AW    source register of each operand (0 = unused)
//  use_t        in   NSRC*TW    cycles from decode until each operand is consumed
//  v_grf        in   NSRC*DW    register-file read data for each operand
//  stage_val    in   STAGES*DW  result value currently available in each stage
//  ext_stall    in   1          external freeze request, e.g. busy multiply unit
//  flush        in   1          kill the instruction now in decode
//  stall        out  1          freeze PC and IF/decode; insert a bubble
//  fwd_val      out  NSRC*DW    operand value to use in decode
//  ent_a        out  STAGES*AW  per-stage destination register (to downstream muxes)
//  ent_t        out  STAGES*TW  per-stage remaining t_new
//  stall_cnt    out  CNT_W      count of cycles with stall=1
// BEHAVIOUR
//  - State: STAGES entries {a, t}. Reset (async, reset=0) clears all entries to
//    0 and clears stall_cnt. Immediately after reset: stall=0, fwd_val=v_grf.
//  - Each clk edge: entry[k+1] <= {a[k], dec(t[k])} for k=0..STAGES-2.
//    The entry in STAGES-1 retires. dec(x) = (x==0) ? 0 : x-1, saturating.
//  - entry[0] <= bubble {0,0} if stall | ext_stall | flush | ~dec_valid.
//    Otherwise entry[0] <= {dec_a_new, dec(dec_t_new)}.
//  - Older entries always advance. Neither stall nor flush holds or clears them.
//  - Operand i match: use_a[i]!=0 and a[k]==use_a[i]. The youngest match
//    (lowest k) is the only one considered.
//  - stall_i = match && t[k] > use_t[i]. stall = OR over i of stall_i.
//    stall is combinational from current inputs and entries. ext_stall does
//    not drive stall.
//  - fwd_val[i] = stage_val[k] if the youngest match has t[k]==0.
//    Otherwise fwd_val[i] = v_grf[i]. With no match, fwd_val[i] = v_grf[i].
//  - If the youngest match has 0<t<=use_t, there is no stall and v_grf is
//    passed through. The downstream stage forwards using ent_a / ent_t.
//  - Register 0 never matches and is never forwarded or stalled on.
//  - The writeback entry (STAGES-1) is forwarded normally. The GRF is not
//    required to write through.
//  - stall_cnt increments on each clk edge where stall=1.
//    It saturates at 2^CNT_W-1 and does not wrap.
//  - Simultaneous flush and stall: a bubble is inserted and the counter still
//    increments.
// TESTING
//  1. Load-use hazard: dec_a_new=2, dec_t_new=2, next cycle use_a0=2,
//     use_t0=0 -> stall=1 for 1 cycle. Next cycle entry1={2,0} and
//     fwd_val0=stage_val[1].
//  2. Priority: entry0={5,0}, entry1={5,0}, stage_val0=0x11, stage_val1=0x22,
//     use_a0=5 -> fwd_val0=0x11, stall=0.
//  3. Register 0: entry0={0,1}, use_a0=0, use_t0=0 -> stall=0, fwd_val0=v_grf0.
//  4. Async reset mid-run: entries populated, stall=1, reset=0 between edges
//     -> all ent_a/ent_t=0, stall=0, stall_cnt=0 before the next edge.
//  5. Flush: dec_valid=1, dec_a_new=7, flush=1 -> after the edge entry0={0,0}.
//     The older entries have shifted one stage.
//  6. Counter saturation: CNT_W=4, stall held for 20 cycles -> stall_cnt=15.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Hazard scoreboard and operand forwarding mux that sits beside decode.
// It tracks the destination register and remaining latency of each in-flight
// producer, raises a stall when an operand is needed before it exists, and
// picks the forwarded value when the youngest producer has finished.
module hazard_forward_unit #(
  parameter int STAGES = 3,
  parameter int NSRC   = 2,
  parameter int AW     = 5,
  parameter int DW     = 32,
  parameter int TW     = 2,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [AW-1:0]        dec_a_new,
  input  logic [TW-1:0]        dec_t_new,
  input  logic [NSRC*AW-1:0]   use_a,
  input  logic [NSRC*TW-1:0]   use_t,
  input  logic [NSRC*DW-1:0]   v_grf,
  input  logic [STAGES*DW-1:0] stage_val,
  input  logic                 ext_stall,
  input  logic                 flush,
  output logic                 stall,
  output logic [NSRC*DW-1:0]   fwd_val,
  output logic [STAGES*AW-1:0] ent_a,
  output logic [STAGES*TW-1:0] ent_t,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic [AW-1:0]      r_a [STAGES];
  logic [TW-1:0]      r_t [STAGES];
  logic [CNT_W-1:0]   r_cnt;

  logic               w_stall;
  logic               w_bubble;
  logic [NSRC-1:0]    w_found;
  logic [NSRC*DW-1:0] w_fwd;

  // Remaining latency counts down by one per stage and stops at zero.
  function automatic logic [TW-1:0] decT(input logic [TW-1:0] x);
    return (x == '0) ? '0 : x - TW'(1);
  endfunction

  // For each operand, only the youngest matching producer matters: stall if
  // its result arrives too late, forward its stage value if it is ready now.
  always_comb begin
    w_stall = 1'b0;
    w_found = '0;
    w_fwd   = v_grf;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = 0; k < STAGES; k++) begin
        if (!w_found[i] && (use_a[i*AW +: AW] != '0) &&
            (r_a[k] == use_a[i*AW +: AW])) begin
          w_found[i] = 1'b1;
          if (r_t[k] > use_t[i*TW +: TW]) begin
            w_stall = 1'b1;
          end
          if (r_t[k] == '0) begin
            w_fwd[i*DW +: DW] = stage_val[k*DW +: DW];
          end
        end
      end
    end
  end

  assign w_bubble = w_stall | ext_stall | flush | ~dec_valid;

  // Shift the scoreboard every cycle; decode enters stage 0 unless it is
  // replaced by a bubble. Older producers always advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_t[k] <= '0;
      end
    end else begin
      for (int k = STAGES - 1; k > 0; k--) begin
        r_a[k] <= r_a[k-1];
        r_t[k] <= decT(r_t[k-1]);
      end
      if (w_bubble) begin
        r_a[0] <= '0;
        r_t[0] <= '0;
      end else begin
        r_a[0] <= dec_a_new;
        r_t[0] <= decT(dec_t_new);
      end
    end
  end

  // Performance counter of stalled cycles, saturating at all ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_ent
    assign ent_a[g*AW +: AW] = r_a[g];
    assign ent_t[g*TW +: TW] = r_t[g];
  end

  assign stall     = w_stall;
  assign fwd_val   = w_fwd;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Testbench for hazard_forward_unit: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_hazard_forward_unit;

  localparam int STAGES  = 3;
  localparam int NSRC    = 2;
  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int TW      = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 dec_valid;
  logic [AW-1:0]        dec_a_new;
  logic [TW-1:0]        dec_t_new;
  logic [NSRC*AW-1:0]   use_a;
  logic [NSRC*TW-1:0]   use_t;
  logic [NSRC*DW-1:0]   v_grf;
  logic [STAGES*DW-1:0] stage_val;
  logic                 ext_stall;
  logic                 flush;
  logic                 stall;
  logic [NSRC*DW-1:0]   fwd_val;
  logic [STAGES*AW-1:0] ent_a;
  logic [STAGES*TW-1:0] ent_t;
  logic [CNT_W-1:0]     stall_cnt;

  hazard_forward_unit #(
    .STAGES(STAGES), .NSRC(NSRC), .AW(AW), .DW(DW), .TW(TW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_a_new(dec_a_new),
    .dec_t_new(dec_t_new), .use_a(use_a), .use_t(use_t), .v_grf(v_grf),
    .stage_val(stage_val), .ext_stall(ext_stall), .flush(flush),
    .stall(stall), .fwd_val(fwd_val), .ent_a(ent_a), .ent_t(ent_t),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nBad = 0;

  // Reference model: index 0 of each queue is the youngest producer.
  int         mA[$];
  int         mT[$];
  int         mCnt;
  logic       expStall;
  logic [DW-1:0] expFwd [NSRC];

  function automatic int decInt(input int x);
    return (x == 0) ? 0 : x - 1;
  endfunction

  function void modelReset();
    mA.delete();
    mT.delete();
    for (int k = 0; k < STAGES; k++) begin
      mA.push_back(0);
      mT.push_back(0);
    end
    mCnt = 0;
  endfunction

  function void modelOutputs();
    int uA;
    int uT;
    expStall = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      expFwd[i] = v_grf[i*DW +: DW];
      uA = int'(use_a[i*AW +: AW]);
      uT = int'(use_t[i*TW +: TW]);
      if (uA != 0) begin
        for (int k = 0; k < STAGES; k++) begin
          if (mA[k] == uA) begin
            if (mT[k] > uT) expStall = 1'b1;
            if (mT[k] == 0) expFwd[i] = stage_val[k*DW +: DW];
            break;
          end
        end
      end
    end
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare every DUT output against the model on the falling edge.
  task automatic checkOutput();
    @(negedge clk);
    modelOutputs();
    cmp("stall", {63'd0, stall}, {63'd0, expStall});
    for (int i = 0; i < NSRC; i++)
      cmp($sformatf("fwd_val[%0d]", i), 64'(fwd_val[i*DW +: DW]), 64'(expFwd[i]));
    for (int k = 0; k < STAGES; k++) begin
      cmp($sformatf("ent_a[%0d]", k), 64'(ent_a[k*AW +: AW]), 64'(mA[k]));
      cmp($sformatf("ent_t[%0d]", k), 64'(ent_t[k*TW +: TW]), 64'(mT[k]));
    end
    cmp("stall_cnt", 64'(stall_cnt), 64'(mCnt));
  endtask

  // Advance the model across the rising edge using the inputs the DUT samples.
  task automatic advanceModel();
    bit bubble;
    @(posedge clk);
    modelOutputs();
    bubble = expStall | ext_stall | flush | !dec_valid;
    if (expStall && mCnt < CNT_MAX) mCnt++;
    for (int k = 0; k < STAGES; k++) mT[k] = decInt(mT[k]);
    mA.push_front(bubble ? 0 : int'(dec_a_new));
    mT.push_front(bubble ? 0 : decInt(int'(dec_t_new)));
    void'(mA.pop_back());
    void'(mT.pop_back());
    #1;
  endtask

  task automatic stepCycle();
    checkOutput();
    advanceModel();
  endtask

  task automatic applyStimulus(input bit v, input int aNew, input int tNew,
                               input int ua0, input int ut0, input int ua1, input int ut1,
                               input bit ext, input bit fl);
    dec_valid = v;
    dec_a_new = AW'(aNew);
    dec_t_new = TW'(tNew);
    use_a[0 +: AW]  = AW'(ua0);
    use_t[0 +: TW]  = TW'(ut0);
    use_a[AW +: AW] = AW'(ua1);
    use_t[TW +: TW] = TW'(ut1);
    ext_stall = ext;
    flush     = fl;
    for (int i = 0; i < NSRC; i++) v_grf[i*DW +: DW] = $urandom();
    for (int k = 0; k < STAGES; k++) stage_val[k*DW +: DW] = $urandom();
  endtask

  // Pulse reset between edges, starting just after a rising edge.
  task automatic doReset();
    reset = 1'b0;
    #1 modelReset();
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_grf = {32'h0000_1234, 32'hAAAA_5555};
    modelReset();

    // Reset state
    checkOutput();
    cmp("reset stall", {63'd0, stall}, 64'd0);
    cmp("reset fwd0", 64'(fwd_val[0 +: DW]), 64'h0000_0000_AAAA_5555);
    cmp("reset cnt", 64'(stall_cnt), 64'd0);
    #2 reset = 1'b1;
    advanceModel();

    // Load-use hazard
    applyStimulus(1, 2, 2, 0, 0, 0, 0, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 2, 0, 0, 0, 0, 0);
    checkOutput();
    cmp("loaduse stall", {63'd0, stall}, 64'd1);
    advanceModel();
    applyStimulus(0, 0, 0, 2, 0, 0, 0, 0, 0);
    stage_val[DW +: DW] = 32'hCAFE_0001;
    checkOutput();
    cmp("loaduse release", {63'd0, stall}, 64'd0);
    cmp("loaduse fwd", 64'(fwd_val[0 +: DW]), 64'hCAFE_0001);
    cmp("loaduse ent1 a", 64'(ent_a[AW +: AW]), 64'd2);
    cmp("loaduse ent1 t", 64'(ent_t[TW +: TW]), 64'd0);
    advanceModel();

    // Youngest match wins
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 5, 0, 0, 0, 0, 0);
    stage_val[0 +: DW]  = 32'h11;
    stage_val[DW +: DW] = 32'h22;
    checkOutput();
    cmp("priority fwd", 64'(fwd_val[0 +: DW]), 64'h11);
    cmp("priority stall", {63'd0, stall}, 64'd0);
    advanceModel();

    // Register 0 never matches
    applyStimulus(1, 0, 2, 0, 0, 0, 0, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_grf[0 +: DW] = 32'h0BAD_0000;
    checkOutput();
    cmp("r0 stall", {63'd0, stall}, 64'd0);
    cmp("r0 fwd", 64'(fwd_val[0 +: DW]), 64'h0BAD_0000);
    cmp("r0 ent0 t", 64'(ent_t[0 +: TW]), 64'd1);
    advanceModel();

    // Asynchronous reset between edges while stalling
    applyStimulus(1, 3, 3, 0, 0, 0, 0, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 3, 0, 0, 0, 0, 0);
    checkOutput();
    cmp("midreset pre stall", {63'd0, stall}, 64'd1);
    #1 reset = 1'b0;
    #1 modelReset();
    cmp("midreset ent_a", 64'(ent_a), 64'd0);
    cmp("midreset ent_t", 64'(ent_t), 64'd0);
    cmp("midreset stall", {63'd0, stall}, 64'd0);
    cmp("midreset cnt", 64'(stall_cnt), 64'd0);
    #1 reset = 1'b1;
    advanceModel();

    // Flush turns the decode slot into a bubble while older entries shift
    applyStimulus(1, 4, 2, 0, 0, 0, 0, 0, 0);
    stepCycle();
    applyStimulus(1, 7, 1, 0, 0, 0, 0, 0, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();
    cmp("flush ent0 a", 64'(ent_a[0 +: AW]), 64'd0);
    cmp("flush ent0 t", 64'(ent_t[0 +: TW]), 64'd0);
    cmp("flush ent1 a", 64'(ent_a[AW +: AW]), 64'd4);
    cmp("flush ent1 t", 64'(ent_t[TW +: TW]), 64'd0);
    advanceModel();

    // Counter saturation: two stalls out of every three cycles
    for (int c = 0; c < 30; c++) begin
      applyStimulus(1, 9, 3, 9, 0, 0, 0, 0, 0);
      stepCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();
    cmp("saturated cnt", 64'(stall_cnt), 64'd15);
    advanceModel();

    // Random traffic over a small register window to provoke hazards
    doReset();
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      stepCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
